// File: rtl/vcr_ir_pkg.sv
// Shared types for the IR frame decoder: VCR op codes,
// command-byte constants, decoder FSM states and the cmd->op map.
package vcr_ir_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_PLAY  = 4'd1,
    OP_STOP  = 4'd2,
    OP_PAUSE = 4'd3,
    OP_REW   = 4'd4,
    OP_FF    = 4'd5,
    OP_REC   = 4'd6,
    OP_EJECT = 4'd7,
    OP_POWER = 4'd8
  } vcr_op_t;

  localparam logic [7:0] CMD_PLAY  = 8'h10;
  localparam logic [7:0] CMD_STOP  = 8'h11;
  localparam logic [7:0] CMD_PAUSE = 8'h12;
  localparam logic [7:0] CMD_REW   = 8'h13;
  localparam logic [7:0] CMD_FF    = 8'h14;
  localparam logic [7:0] CMD_REC   = 8'h15;
  localparam logic [7:0] CMD_EJECT = 8'h16;
  localparam logic [7:0] CMD_POWER = 8'h17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_MAP,
    S_ENQ
  } ir_state_t;

  function automatic vcr_op_t map_cmd(input logic [7:0] cmd);
    vcr_op_t op;
    case (cmd)
      CMD_PLAY:  op = OP_PLAY;
      CMD_STOP:  op = OP_STOP;
      CMD_PAUSE: op = OP_PAUSE;
      CMD_REW:   op = OP_REW;
      CMD_FF:    op = OP_FF;
      CMD_REC:   op = OP_REC;
      CMD_EJECT: op = OP_EJECT;
      CMD_POWER: op = OP_POWER;
      default:   op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// Show-ahead command FIFO. Ports: clk, readReset (async, high),
// push/wdata, pop, rdata (head, zero when empty), full, empty.
// A push while full is taken only if a pop happens in the same cycle.
module ir_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             readReset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge readReset) begin
    if (readReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ir_frame_decoder.sv
// IR remote frame decoder: edge-detects push_in, checks the 32-bit
// frame, maps cmd to a VCR op and queues {op, addr}. Ports: clk,
// readReset, push_in, frame_in, cmd_ready -> cmd_valid, cmd_op,
// cmd_addr, frame_err, overflow, err_count. Optional build macro
// IR_ADDR_FILTER_EN rejects frames whose addr != DEV_ADDR.
module ir_frame_decoder
  import vcr_ir_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] DEV_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        readReset,
  input  logic        push_in,
  input  logic [31:0] frame_in,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output vcr_op_t     cmd_op,
  output logic [7:0]  cmd_addr,
  output logic        frame_err,
  output logic        overflow,
  output logic [7:0]  err_count
);

`ifdef IR_ADDR_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  ir_state_t   state_q;
  ir_state_t   state_d;
  logic        push_r;
  logic        push_q;
  logic        armed;
  logic        rise;
  logic [31:0] frame_r;
  vcr_op_t     op_r;
  logic        pass;
  logic        fail;
  logic        enq;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [11:0] head;
  logic [7:0]  addr;
  logic [7:0]  cmd;

  assign addr = frame_r[31:24];
  assign cmd  = frame_r[15:8];

  // armed stays low after reset until push_in is seen low, so a
  // level still high at release is never taken as a new edge.
  assign rise = push_r & ~push_q & armed;

  assign pass = (addr == ~frame_r[23:16])
              && (cmd == ~frame_r[7:0])
              && (!FILTER || addr == DEV_ADDR);

  always_comb begin
    state_d = state_q;
    fail    = 1'b0;
    enq     = 1'b0;
    case (state_q)
      S_IDLE:  if (rise) state_d = S_CHECK;
      S_CHECK: begin
        if (pass) begin
          state_d = S_MAP;
        end else begin
          state_d = S_IDLE;
          fail    = 1'b1;
        end
      end
      S_MAP: begin
        if (map_cmd(cmd) != OP_NONE) begin
          state_d = S_ENQ;
        end else begin
          state_d = S_IDLE;
          fail    = 1'b1;
        end
      end
      S_ENQ: begin
        enq     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge readReset) begin
    if (readReset) begin
      state_q   <= S_IDLE;
      push_r    <= 1'b0;
      push_q    <= 1'b0;
      armed     <= 1'b0;
      frame_r   <= '0;
      op_r      <= OP_NONE;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      push_r    <= push_in;
      push_q    <= push_r;
      armed     <= armed | ~push_in;
      frame_err <= fail;
      if (state_q == S_IDLE && rise) frame_r <= frame_in;
      if (state_q == S_MAP) op_r <= map_cmd(cmd);
      if (enq && fifo_full && !pop) overflow <= 1'b1;
      if (fail && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign pop       = ~fifo_empty & cmd_ready;
  assign cmd_valid = ~fifo_empty;
  assign cmd_op    = vcr_op_t'(head[11:8]);
  assign cmd_addr  = head[7:0];

  ir_cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(12)
  ) u_fifo (
    .clk      (clk),
    .readReset(readReset),
    .push     (enq),
    .pop      (pop),
    .wdata    ({op_r, addr}),
    .rdata    (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Directed bench for ir_frame_decoder: latency, frame checks,
// overflow, concurrent pop, address filter and mid-frame reset.
module tb_ir_frame_decoder;
  import vcr_ir_pkg::*;

  logic        clk;
  logic        readReset;
  logic        push_in;
  logic [31:0] frame_in;
  logic        cmd_ready;
  logic        cmd_valid;
  vcr_op_t     cmd_op;
  logic [7:0]  cmd_addr;
  logic        frame_err;
  logic        overflow;
  logic [7:0]  err_count;

  int vecs = 0;
  int errs = 0;

  ir_frame_decoder #(.DEPTH(4), .DEV_ADDR(8'h5A)) dut (
    .clk      (clk),
    .readReset(readReset),
    .push_in  (push_in),
    .frame_in (frame_in),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .frame_err(frame_err),
    .overflow (overflow),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_frame(input logic [31:0] f, input int hold,
                           input int cycles, output int pulses);
    pulses = 0;
    @(negedge clk);
    frame_in = f;
    push_in  = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (frame_err) pulses++;
      if (i == hold - 1) push_in = 1'b0;
    end
    push_in = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    readReset = 1'b1;
    push_in   = 1'b0;
    frame_in  = '0;
    cmd_ready = 1'b0;
    #12;
    vecs++;
    if ({cmd_valid, cmd_op, cmd_addr, frame_err, overflow, err_count}
        !== 22'd0) begin
      errs++;
      $display("FAIL reset outs got %h exp 0",
        {cmd_valid, cmd_op, cmd_addr, frame_err, overflow, err_count});
    end
    @(negedge clk);
    readReset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    int pulses;
    pulses = 0;
    @(negedge clk);
    frame_in = 32'h00FF10EF;
    push_in  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin
        vecs++;
        if (cmd_valid !== 1'b0) begin
          errs++;
          $display("FAIL lat_n3 valid got %b exp 0", cmd_valid);
        end
      end
    end
    vecs++;
    if (cmd_valid !== 1'b1 || cmd_op !== OP_PLAY || cmd_addr !== 8'h00)
    begin
      errs++;
      $display("FAIL lat_n4 got v=%b op=%0d a=%h exp v=1 op=1 a=00",
        cmd_valid, cmd_op, cmd_addr);
    end
    for (int i = 0; i < 46; i++) begin
      @(posedge clk);
      #1;
      if (frame_err) pulses++;
    end
    push_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    vecs++;
    if (pulses !== 0 || cmd_valid !== 1'b1) begin
      errs++;
      $display("FAIL hold50 got err=%0d v=%b exp err=0 v=1",
        pulses, cmd_valid);
    end
    pop_one();
    vecs++;
    if (cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL hold50_one got v=%b exp 0 after one pop",
        cmd_valid);
    end
  endtask

  task automatic test_bad_check();
    int pulses;
    run_frame(32'h00FF10EE, 3, 8, pulses);
    vecs++;
    if (pulses !== 1 || err_count !== 8'd1 || cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL bad_check got p=%0d cnt=%0d v=%b exp 1 1 0",
        pulses, err_count, cmd_valid);
    end
  endtask

  task automatic test_unknown_cmd();
    int pulses;
    run_frame(32'h00FF20DF, 3, 8, pulses);
    vecs++;
    if (pulses !== 1 || err_count !== 8'd2 || cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL unknown got p=%0d cnt=%0d v=%b exp 1 2 0",
        pulses, err_count, cmd_valid);
    end
  endtask

  task automatic test_empty_pop();
    int pulses;
    @(negedge clk);
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    cmd_ready = 1'b0;
    run_frame(32'h00FF17E8, 3, 8, pulses);
    vecs++;
    if (cmd_valid !== 1'b1 || cmd_op !== OP_POWER) begin
      errs++;
      $display("FAIL empty_pop got v=%b op=%0d exp v=1 op=8",
        cmd_valid, cmd_op);
    end
    pop_one();
    vecs++;
    if (cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL empty_pop_drain got v=%b exp 0", cmd_valid);
    end
  endtask

  task automatic test_overflow();
    int pulses;
    logic [7:0] c;
    vcr_op_t exp_ops [4];
    exp_ops = '{OP_STOP, OP_PAUSE, OP_REW, OP_REC};
    for (int i = 0; i < 5; i++) begin
      c = 8'h10 + 8'(i);
      run_frame({8'h00, 8'hFF, c, ~c}, 3, 8, pulses);
      if (i == 3) begin
        vecs++;
        if (overflow !== 1'b0 || cmd_op !== OP_PLAY) begin
          errs++;
          $display("FAIL fill4 got ovf=%b op=%0d exp 0 1",
            overflow, cmd_op);
        end
      end
    end
    vecs++;
    if (overflow !== 1'b1 || err_count !== 8'd2) begin
      errs++;
      $display("FAIL ovf5 got ovf=%b cnt=%0d exp 1 2",
        overflow, err_count);
    end
    @(negedge clk);
    frame_in = 32'h00FF15EA;
    push_in  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    push_in   = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++;
      if (cmd_valid !== 1'b1 || cmd_op !== exp_ops[i]
          || cmd_addr !== 8'h00) begin
        errs++;
        $display("FAIL drain%0d got v=%b op=%0d exp v=1 op=%0d",
          i, cmd_valid, cmd_op, exp_ops[i]);
      end
      pop_one();
    end
    vecs++;
    if (cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL drain_empty got v=%b exp 0", cmd_valid);
    end
  endtask

  task automatic test_addr_filter();
    int pulses;
    run_frame(32'h00FF11EE, 3, 8, pulses);
`ifdef IR_ADDR_FILTER_EN
    vecs++;
    if (pulses !== 1 || cmd_valid !== 1'b0 || err_count !== 8'd3) begin
      errs++;
      $display("FAIL filt_rej got p=%0d v=%b cnt=%0d exp 1 0 3",
        pulses, cmd_valid, err_count);
    end
`else
    vecs++;
    if (pulses !== 0 || cmd_valid !== 1'b1 || cmd_op !== OP_STOP
        || cmd_addr !== 8'h00) begin
      errs++;
      $display("FAIL nofilt got p=%0d v=%b op=%0d a=%h exp 0 1 2 00",
        pulses, cmd_valid, cmd_op, cmd_addr);
    end
    pop_one();
`endif
    run_frame(32'h5AA511EE, 3, 8, pulses);
    vecs++;
    if (pulses !== 0 || cmd_valid !== 1'b1 || cmd_op !== OP_STOP
        || cmd_addr !== 8'h5A) begin
      errs++;
      $display("FAIL filt_acc got p=%0d v=%b op=%0d a=%h exp 0 1 2 5a",
        pulses, cmd_valid, cmd_op, cmd_addr);
    end
    pop_one();
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    frame_in = 32'h00FF12ED;
    push_in  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    readReset = 1'b1;
    #1;
    vecs++;
    if ({cmd_valid, cmd_op, cmd_addr, frame_err, overflow, err_count}
        !== 22'd0) begin
      errs++;
      $display("FAIL mid_rst got %h exp 0",
        {cmd_valid, cmd_op, cmd_addr, frame_err, overflow, err_count});
    end
    @(negedge clk);
    readReset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    vecs++;
    if (cmd_valid !== 1'b0 || err_count !== 8'd0) begin
      errs++;
      $display("FAIL held_high got v=%b cnt=%0d exp 0 0",
        cmd_valid, err_count);
    end
    push_in = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(32'h00FF12ED, 3, 8, pulses);
    vecs++;
    if (cmd_valid !== 1'b1 || cmd_op !== OP_PAUSE) begin
      errs++;
      $display("FAIL toggle got v=%b op=%0d exp 1 3",
        cmd_valid, cmd_op);
    end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bad_check();
    test_unknown_cmd();
    test_empty_pop();
    test_overflow();
    test_addr_filter();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/ir_frame_decoder.md
IR_FRAME_DECODER -- requirements
Module: ir_frame_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter DEV_ADDR, default 8'h00, device address accepted when filtering is enabled.
REQ-003 SHALL have ports: clk  in  1  system clock.
REQ-004 SHALL have ports: readReset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: push_in  in  1  frame-ready level from the upstream IR reader; may stay high for many cycles.
REQ-006 SHALL have ports: frame_in  in  32  raw frame: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
REQ-007 SHALL have ports: cmd_ready  in  1  consumer accepts the head command.
REQ-008 SHALL have ports: cmd_valid  out  1  FIFO head is valid.
REQ-009 SHALL have ports: cmd_op  out  4  decoded VCR operation (vcr_op_t).
REQ-010 SHALL have ports: cmd_addr  out  8  address byte of the head frame.
REQ-011 SHALL have ports: frame_err  out  1  one-cycle pulse on a rejected frame.
REQ-012 SHALL have ports: overflow  out  1  sticky; set when a valid command is dropped because the FIFO is full.
REQ-013 SHALL have ports: err_count  out  8  saturating count of rejected frames.

Function
REQ-014 SHALL register push_in and act only on its rising edge; a held-high level yields exactly one frame.
REQ-015 SHALL latch frame_in in the cycle the rising edge is detected (FSM IDLE->CHECK).
REQ-016 FSM SHALL have states IDLE, CHECK, MAP, ENQ; CHECK->MAP on pass, CHECK->IDLE on fail, MAP->ENQ on known op, MAP->IDLE on unknown op, ENQ->IDLE unconditionally.
REQ-017 CHECK SHALL pass only if addr == ~(~addr byte) and cmd == ~(~cmd byte), bitwise over all 8 bits.
REQ-018 MAP SHALL translate cmd 0x10 PLAY=1, 0x11 STOP=2, 0x12 PAUSE=3, 0x13 REW=4, 0x14 FF=5, 0x15 REC=6, 0x16 EJECT=7, 0x17 POWER=8; any other cmd is unknown (op 0 never enqueued).
REQ-019 Each failure (CHECK fail, unknown op, address mismatch per REQ-027) SHALL pulse frame_err for exactly one cycle and increment err_count, saturating at 255.
REQ-020 Rising edges of push_in arriving outside IDLE SHALL be ignored without error.
REQ-021 ENQ SHALL write {op, addr} into the FIFO; if full, the entry is dropped and overflow set, unless a pop occurs in the same cycle, in which case the write is accepted.
REQ-022 FIFO SHALL be show-ahead: cmd_valid/cmd_op/cmd_addr reflect the head; pop on cmd_valid && cmd_ready.
REQ-023 Latency: rising edge sampled at cycle N -> cmd_valid high at N+4 when the FIFO was empty.
REQ-024 cmd_ready while empty SHALL have no effect; pointers wrap modulo DEPTH with a separate full/empty count.

Reset
REQ-025 readReset SHALL asynchronously force FSM IDLE, FIFO empty, cmd_valid=0, cmd_op=0, cmd_addr=0, frame_err=0, overflow=0, err_count=0, edge register=0.
REQ-026 Reset mid-frame SHALL discard the in-flight frame; after release a push_in already high SHALL NOT be taken as a rising edge until it falls and rises again.

Configuration
REQ-027 With IR_ADDR_FILTER_EN defined, CHECK SHALL also fail when addr != DEV_ADDR; without it, any address passes and DEV_ADDR is unused.

Structure
REQ-028 Package vcr_ir_pkg SHALL hold vcr_op_t enum, the command-byte constants, and the FSM state typedef.
REQ-029 FIFO SHALL be a sub-module ir_cmd_fifo (params DEPTH, WIDTH=12) with push/pop/full/empty.

Verification
REQ-030 frame 0x00FF10EF, push_in high 50 cycles -> one entry, cmd_op=1, cmd_addr=0x00, valid at N+4.
REQ-031 frame 0x00FF10EE -> frame_err one pulse, err_count=1, no entry.
REQ-032 frame 0x00FF20DF (unknown cmd) -> frame_err, err_count increments, FIFO unchanged.
REQ-033 DEPTH=4, cmd_ready=0, five valid frames -> four entries, overflow=1; sixth frame with concurrent pop accepted.
REQ-034 IR_ADDR_FILTER_EN, DEV_ADDR=0x5A: 0x00FF11EE rejected, 0x5AA511EE accepted as STOP.
REQ-035 readReset asserted in CHECK with push_in held high -> all outputs zero, no entry after release until push_in toggles.
